ti_keypad_scanner: RTL

- Front end for the tiCalc datapath: scans a 4-row x 5-column calculator keypad matrix and debounces each key.
- Emits exactly one single-cycle keystroke per physical press on the keyStroke_t bus that tiCalc consumes.
- The bus carries the same op/num pairs the tiCalc bench drives: NUMBER with num 0-9, PLUS, MINUS, NEGATE, LP, RP, EQUALS, CLEAR. The idle value is op NONE.

---
 rtl/ti_keypad_scanner.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ti_keypad_scanner.sv
// ti_keypad_scanner: scans a 4-row x 5-column calculator keypad, debounces each
// press and release, and emits one tiCalc keystroke per physical press.
package ti_keypad_pkg;
  typedef enum logic [3:0] {
    NONE   = 4'd0,
    NUMBER = 4'd1,
    PLUS   = 4'd2,
    MINUS  = 4'd3,
    NEGATE = 4'd4,
    LP     = 4'd5,
    RP     = 4'd6,
    EQUALS = 4'd7,
    CLEAR  = 4'd8
  } opType_t;

  typedef struct packed {
    opType_t    op;
    logic [3:0] num;
  } keyStroke_t;
endpackage

module ti_keypad_scanner
  import ti_keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [3:0] row_n,
  output logic [4:0] col_n,
  output keyStroke_t keyOut,
  output logic       unmapped
);

  localparam int            DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB_N      = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_WAIT_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync_q;
  logic [3:0]    rs_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [4:0]    col_n_q, col_n_d;
  logic [4:0]    key_q, key_d;
  logic [3:0]    cnt_q, cnt_d;
  keyStroke_t    key_out_q, key_out_d;
  logic          unmapped_q, unmapped_d;

  logic          sample;
  logic          any_low;
  logic          match;
  logic [1:0]    row_now;
  logic [4:0]    idx_now;
  logic [4:0]    col_rot;
  logic [3:0]    cnt_inc;
  keyStroke_t    emit_k;

  function automatic keyStroke_t key_map(input logic [4:0] idx);
    keyStroke_t k;
    k.op  = NONE;
    k.num = 4'd0;
    case (idx)
      5'd0:  begin k.op = NUMBER; k.num = 4'd7; end
      5'd1:  begin k.op = NUMBER; k.num = 4'd4; end
      5'd2:  begin k.op = NUMBER; k.num = 4'd1; end
      5'd3:  begin k.op = NUMBER; k.num = 4'd0; end
      5'd4:  begin k.op = NUMBER; k.num = 4'd8; end
      5'd5:  begin k.op = NUMBER; k.num = 4'd5; end
      5'd6:  begin k.op = NUMBER; k.num = 4'd2; end
      5'd7:  k.op = NEGATE;
      5'd8:  begin k.op = NUMBER; k.num = 4'd9; end
      5'd9:  begin k.op = NUMBER; k.num = 4'd6; end
      5'd10: begin k.op = NUMBER; k.num = 4'd3; end
      5'd11: k.op = EQUALS;
      5'd12: k.op = PLUS;
      5'd13: k.op = MINUS;
      5'd14: k.op = LP;
      5'd15: k.op = RP;
      5'd16: k.op = CLEAR;
      default: ;
    endcase
    return k;
  endfunction

  function automatic logic [2:0] col_index(input logic [4:0] cn);
    logic [2:0] c;
    case (cn)
      5'b11101: c = 3'd1;
      5'b11011: c = 3'd2;
      5'b10111: c = 3'd3;
      5'b01111: c = 3'd4;
      default:  c = 3'd0;
    endcase
    return c;
  endfunction

  // Lowest-numbered active row wins when several are low together.
  function automatic logic [1:0] low_row(input logic [3:0] rs);
    logic [1:0] r;
    if (!rs[0])      r = 2'd0;
    else if (!rs[1]) r = 2'd1;
    else if (!rs[2]) r = 2'd2;
    else             r = 2'd3;
    return r;
  endfunction

  always_comb begin
    sample  = (dwell_q == DWELL_LAST);
    any_low = ~&rs_q;
    row_now = low_row(rs_q);
    idx_now = {col_index(col_n_q), row_now};
    match   = any_low && (row_now == key_q[1:0]);
    col_rot = {col_n_q[3:0], col_n_q[4]};
    cnt_inc = cnt_q + 4'd1;

    dwell_d    = sample ? '0 : dwell_q + DW'(1);
    state_d    = state_q;
    col_n_d    = col_n_q;
    key_d      = key_q;
    cnt_d      = cnt_q;
    key_out_d  = '{op: NONE, num: 4'd0};
    unmapped_d = 1'b0;
    emit_k     = '{op: NONE, num: 4'd0};

    case (state_q)
      ST_SCAN: begin
        if (sample) begin
          if (any_low) begin
            key_d   = idx_now;
            cnt_d   = 4'd1;
            state_d = (DEB_N == 4'd1) ? ST_EMIT : ST_DEBOUNCE;
          end else begin
            col_n_d = col_rot;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (sample) begin
          if (match) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_N) state_d = ST_EMIT;
          end else begin
            cnt_d   = 4'd0;
            state_d = ST_SCAN;
            col_n_d = col_rot;
          end
        end
      end
      ST_EMIT: begin
        cnt_d   = 4'd0;
        state_d = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (sample) begin
          if (!rs_q[key_q[1:0]]) begin
            cnt_d = 4'd0;
          end else if (cnt_inc == DEB_N) begin
            cnt_d   = 4'd0;
            state_d = ST_SCAN;
            col_n_d = col_rot;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = ST_SCAN;
    endcase

    // Load the keystroke on entry so the pulse coincides with the EMIT cycle.
    if (state_d == ST_EMIT) begin
      emit_k     = key_map(key_d);
      key_out_d  = emit_k;
      unmapped_d = (emit_k.op == NONE);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= ST_SCAN;
      sync_q     <= 4'hF;
      rs_q       <= 4'hF;
      dwell_q    <= '0;
      col_n_q    <= 5'b11110;
      key_q      <= 5'd0;
      cnt_q      <= 4'd0;
      key_out_q  <= '{op: NONE, num: 4'd0};
      unmapped_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= row_n;
      rs_q       <= sync_q;
      dwell_q    <= dwell_d;
      col_n_q    <= col_n_d;
      key_q      <= key_d;
      cnt_q      <= cnt_d;
      key_out_q  <= key_out_d;
      unmapped_q <= unmapped_d;
    end
  end

  assign col_n    = col_n_q;
  assign keyOut   = key_out_q;
  assign unmapped = unmapped_q;

endmodule
